// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Brief    : Shared types and sizing helpers for the debounce_ev conditioner.
// Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Width of a counter that must hold every value in 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// Module   : debounce_chan
// Brief    : One channel: synchroniser, symmetric debounce, edge and repeat pulses.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int ACTIVE_LOW    = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int TIMEOUT       = 50000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_repeat_pulse
);

    localparam int              c_db_w     = cnt_width(TIMEOUT);
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(TIMEOUT - 1);
    localparam logic            c_pin_idle = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_db_w-1:0]      r_db_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   w_act;
    logic                   w_accept;

    assign w_act    = (ACTIVE_LOW != 0) ? ~r_sync[SYNC_STAGES-1] : r_sync[SYNC_STAGES-1];
    assign w_accept = (w_act != r_level) && (r_db_cnt == c_db_last);

    always_ff @(posedge clk) begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (reset) begin
            r_sync   <= {SYNC_STAGES{c_pin_idle}};
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            if (w_act == r_level) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_level   <= w_act;
                r_db_cnt  <= '0;
                r_press   <= w_act;
                r_release <= ~w_act;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign o_level         = r_level;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;

    if (REPEAT_EN != 0) begin : g_repeat
        localparam int                 c_rep_w      = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
        localparam logic [c_rep_w-1:0] c_delay_last = c_rep_w'(REPEAT_DELAY - 1);
        localparam logic [c_rep_w-1:0] c_period_last = c_rep_w'(REPEAT_PERIOD - 1);

        rep_state_t         r_state;
        logic [c_rep_w-1:0] r_rep_cnt;
        logic               r_rep_pulse;
        logic               w_press_edge;
        logic               w_release_edge;

        assign w_press_edge   = w_accept & w_act;
        assign w_release_edge = w_accept & ~w_act;

        // Release is tested first so it suppresses a repeat due on the same edge.
        always_ff @(posedge clk) begin
            r_rep_pulse <= 1'b0;
            if (reset) begin
                r_state   <= IDLE;
                r_rep_cnt <= '0;
            end else if (w_release_edge) begin
                r_state   <= IDLE;
                r_rep_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_press_edge) begin
                            r_state   <= DELAY;
                            r_rep_cnt <= '0;
                        end
                    end
                    DELAY: begin
                        if (r_rep_cnt == c_delay_last) begin
                            r_rep_pulse <= 1'b1;
                            r_rep_cnt   <= '0;
                            r_state     <= REPEAT;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (r_rep_cnt == c_period_last) begin
                            r_rep_pulse <= 1'b1;
                            r_rep_cnt   <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_rep_cnt <= '0;
                    end
                endcase
            end
        end

        assign o_repeat_pulse = r_rep_pulse;
    end else begin : g_no_repeat
        assign o_repeat_pulse = 1'b0;
    end

endmodule : debounce_chan
`default_nettype wire

// File: rtl/debounce_ev.sv
`default_nettype none
// ============================================================================
// Module   : debounce_ev
// Brief    : Multi-channel key/switch conditioner with level and event pulses.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_ev
    import debounce_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int TIMEOUT       = 50000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] repeat_pulse
);

    if (WIDTH < 1) begin : g_chk_width
        $error("debounce_ev: WIDTH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("debounce_ev: SYNC_STAGES must be >= 2");
    end
    if (TIMEOUT < 1) begin : g_chk_timeout
        $error("debounce_ev: TIMEOUT must be >= 1");
    end
    if (REPEAT_DELAY < 1) begin : g_chk_delay
        $error("debounce_ev: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_chk_period
        $error("debounce_ev: REPEAT_PERIOD must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .ACTIVE_LOW    (ACTIVE_LOW),
            .SYNC_STAGES   (SYNC_STAGES),
            .TIMEOUT       (TIMEOUT),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk             (clk),
            .reset           (reset),
            .i_pin           (data_in[i]),
            .o_level         (level[i]),
            .o_press_pulse   (press_pulse[i]),
            .o_release_pulse (release_pulse[i]),
            .o_repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule : debounce_ev
`default_nettype wire
